fetch_queue_unit: RTL

//  Parametrised next-generation fetch stage. Owns the PC, issues sequential

---
 rtl/if_pkg.sv | 25 ++
 rtl/fetch_queue_unit_if.sv | 39 +++
 rtl/fa_nbit.sv | 29 ++
 rtl/fetch_fifo.sv | 80 ++++++++
 rtl/fetch_queue_unit.sv | 142 ++++++++++++++
 5 files changed

// File: rtl/if_pkg.sv
`default_nettype none
// ============================================================================
// Package : if_pkg
// Purpose : Shared defaults and types for the fetch queue unit.
//           Address/instruction widths, queue depth, PC increment,
//           reset PC, and the {pc, pcplus4, instr} entry layout.
// Revision: 1.0 - initial release
// ============================================================================
package if_pkg;

  localparam int IF_ADDR_W  = 32;
  localparam int IF_INSTR_W = 32;
  localparam int IF_DEPTH   = 4;
  localparam int IF_PC_INC  = 4;

  localparam logic [IF_ADDR_W-1:0] IF_RESET_PC = '0;

  typedef struct packed {
    logic [IF_ADDR_W-1:0]  pc;
    logic [IF_ADDR_W-1:0]  pcplus4;
    logic [IF_INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_queue_unit_if.sv
`default_nettype none
// ============================================================================
// Interface : fetch_queue_unit_if
// Purpose   : Bundles the fetch unit's redirect, imem and decode-side
//             handshake signals.
// Modports  : master - the fetch unit (drives imem_req/addr, out_*, q_count)
//             slave  - the environment (drives leap, imem_instr, out_ready)
// Revision  : 1.0 - initial release
// ============================================================================
interface fetch_queue_unit_if #(
  parameter int ADDR_W  = if_pkg::IF_ADDR_W,
  parameter int INSTR_W = if_pkg::IF_INSTR_W,
  parameter int DEPTH   = if_pkg::IF_DEPTH
);

  logic                     leap;
  logic [ADDR_W-1:0]        leap_addr;
  logic                     imem_req;
  logic [ADDR_W-1:0]        imem_addr;
  logic [INSTR_W-1:0]       imem_instr;
  logic                     out_valid;
  logic                     out_ready;
  logic [ADDR_W-1:0]        out_pc;
  logic [ADDR_W-1:0]        out_pcplus4;
  logic [INSTR_W-1:0]       out_instr;
  logic [$clog2(DEPTH):0]   q_count;

  modport master (
    input  leap, leap_addr, imem_instr, out_ready,
    output imem_req, imem_addr, out_valid, out_pc, out_pcplus4, out_instr, q_count
  );

  modport slave (
    output leap, leap_addr, imem_instr, out_ready,
    input  imem_req, imem_addr, out_valid, out_pc, out_pcplus4, out_instr, q_count
  );

endinterface
`default_nettype wire

// File: rtl/fa_nbit.sv
`default_nettype none
// ============================================================================
// Module  : fa_nbit
// Purpose : N-bit ripple-carry adder, sum = a + b + cin (mod 2^N).
// Ports   : a, b [N-1:0] operands; cin carry in; sum [N-1:0] result.
// Revision: 1.0 - initial release
// ============================================================================
module fa_nbit #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum
);

  // Carry-out of the top bit is dropped: callers want modular wrap.
  always_comb begin
    logic carry;
    carry = cin;
    sum   = '0;
    for (int i = 0; i < N; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module  : fetch_fifo
// Purpose : Synchronous FIFO holding fetched entries. Flush dominates
//           push/pop. Head data is the entry at the read pointer.
// Ports   : clk, reset (async active-low); push/din; pop; flush;
//           head [WIDTH-1:0]; count [$clog2(DEPTH):0] occupancy.
// Revision: 1.0 - initial release
// ============================================================================
module fetch_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  input  logic                   flush,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  // A push into a full FIFO is accepted only when a pop frees a slot.
  assign do_pop  = pop && (cnt_q != '0);
  assign do_push = push && ((cnt_q != CNT_W'(DEPTH)) || do_pop);

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_q] = din;
        wr_d        = wr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_d = rd_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign head  = mem_q[rd_q];
  assign count = cnt_q;

endmodule
`default_nettype wire

// File: rtl/fetch_queue_unit.sv
`default_nettype none
// ============================================================================
// Module  : fetch_queue_unit
// Purpose : Fetch stage. Owns the PC, issues sequential imem requests,
//           buffers returned instructions in a DEPTH-entry queue and hands
//           {pc, pcplus4, instr} to decode over valid/ready. A leap
//           redirects the PC and flushes the queue and inflight response.
// Ports   : clk, reset (async active-low); bus (fetch_queue_unit_if.master)
//           carrying leap/leap_addr, imem_req/addr/instr,
//           out_valid/ready/pc/pcplus4/instr and q_count.
//           With FETCH_STATS_EN defined: stat_fetched, stat_flushed.
// Config  : FETCH_STATS_EN - adds saturating dequeue/flush counters.
// Revision: 1.0 - initial release
// ============================================================================
module fetch_queue_unit
  import if_pkg::*;
#(
  parameter int                ADDR_W   = IF_ADDR_W,
  parameter int                INSTR_W  = IF_INSTR_W,
  parameter int                DEPTH    = IF_DEPTH,
  parameter int                PC_INC   = IF_PC_INC,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IF_RESET_PC)
) (
  input  logic        clk,
  input  logic        reset,
`ifdef FETCH_STATS_EN
  output logic [31:0] stat_fetched,
  output logic [31:0] stat_flushed,
`endif
  fetch_queue_unit_if.master bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int ENT_W = 2 * ADDR_W + INSTR_W;

  logic [ADDR_W-1:0] pc_q, pc_d, saved_pc_q, saved_pc_d;
  logic [ADDR_W-1:0] pc_next, saved_pc_next;
  logic              inflight_q, inflight_d;
  logic [CNT_W-1:0]  count;
  logic [CNT_W:0]    occupancy;
  logic              issue, push, pop, valid;
  logic [ENT_W-1:0]  head;

  // Credit check includes the inflight response so the return path can
  // always enqueue. Issue is held off while reset is asserted.
  assign occupancy = {1'b0, count} + (CNT_W+1)'(inflight_q);
  assign issue     = reset && !bus.leap && (occupancy < (CNT_W+1)'(DEPTH));
  assign push      = inflight_q && !bus.leap;
  assign valid     = (count != '0);
  // A handshake coinciding with a leap is void.
  assign pop       = valid && bus.out_ready && !bus.leap;

  fa_nbit #(.N(ADDR_W)) u_pc_inc (
    .a   (pc_q),
    .b   (ADDR_W'(PC_INC)),
    .cin (1'b0),
    .sum (pc_next)
  );

  fa_nbit #(.N(ADDR_W)) u_saved_inc (
    .a   (saved_pc_q),
    .b   (ADDR_W'(PC_INC)),
    .cin (1'b0),
    .sum (saved_pc_next)
  );

  always_comb begin
    pc_d       = pc_q;
    saved_pc_d = saved_pc_q;
    inflight_d = issue;
    if (bus.leap) begin
      pc_d = bus.leap_addr;
    end else if (issue) begin
      pc_d       = pc_next;
      saved_pc_d = pc_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q       <= RESET_PC;
      saved_pc_q <= '0;
      inflight_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      saved_pc_q <= saved_pc_d;
      inflight_q <= inflight_d;
    end
  end

  fetch_fifo #(.WIDTH(ENT_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   ({saved_pc_q, saved_pc_next, bus.imem_instr}),
    .pop   (pop),
    .flush (bus.leap),
    .head  (head),
    .count (count)
  );

  assign bus.imem_req    = issue;
  assign bus.imem_addr   = pc_q;
  assign bus.out_valid   = valid;
  assign bus.out_pc      = head[ENT_W-1 -: ADDR_W];
  assign bus.out_pcplus4 = head[ADDR_W+INSTR_W-1 -: ADDR_W];
  assign bus.out_instr   = head[INSTR_W-1:0];
  assign bus.q_count     = count;

`ifdef FETCH_STATS_EN
  logic [31:0] fetched_q, fetched_d, flushed_q, flushed_d;
  logic [32:0] flush_sum;

  // Flushed total counts queued entries plus the discarded inflight one.
  always_comb begin
    fetched_d = fetched_q;
    if (pop && (fetched_q != '1)) begin
      fetched_d = fetched_q + 32'd1;
    end
    flush_sum = {1'b0, flushed_q} + 33'(occupancy);
    flushed_d = flushed_q;
    if (bus.leap) begin
      flushed_d = flush_sum[32] ? '1 : flush_sum[31:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetched_q <= '0;
      flushed_q <= '0;
    end else begin
      fetched_q <= fetched_d;
      flushed_q <= flushed_d;
    end
  end

  assign stat_fetched = fetched_q;
  assign stat_flushed = flushed_q;
`endif

endmodule
`default_nettype wire
